if_id_buffer: RTL



---
 rtl/if_id_buffer_if.sv | 45 ++++
 rtl/if_id_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/if_id_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer_if
//  Description : Fetch-to-decode bundle for the IF/ID elastic buffer.
//                Carries the fetch triple (pc, inst, pc4) with its valid/ready
//                handshake, the decode-side payload with its handshake, the
//                flush request and the occupancy status.
//                  master : fetch/decode/control side (drives if_*, id_ready,
//                           flush; observes if_ready, id_*, occupancy)
//                  slave  : the buffer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_id_buffer_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    // Fetch side
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc4;
    logic            if_ready;

    // Decode side
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [ILEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc4;
    logic            id_ready;

    // Control / status
    logic            flush;
    logic [1:0]      occupancy;

    modport master (
        output if_valid, if_pc, if_inst, if_pc4, id_ready, flush,
        input  if_ready, id_valid, id_pc, id_inst, id_pc4, occupancy
    );

    modport slave (
        input  if_valid, if_pc, if_inst, if_pc4, id_ready, flush,
        output if_ready, id_valid, id_pc, id_inst, id_pc4, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : Two-entry elastic pipeline register between instruction
//                fetch and decode. The OUT register drives decode directly;
//                the SKID register absorbs one extra entry so that decode's
//                ready never reaches fetch's ready combinationally.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous reset, active-low
//                bus  - if_id_buffer_if.slave
//                       if_valid/if_pc/if_inst/if_pc4 in, if_ready out
//                       id_valid/id_pc/id_inst/id_pc4 out, id_ready in
//                       flush in, occupancy out (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
    parameter int              XLEN = 64,
    parameter int              ILEN = 32,
    parameter logic [ILEN-1:0] NOP  = 32'h00000013
) (
    input  wire logic     clk,
    input  wire logic     rst,
    if_id_buffer_if.slave bus
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_out_pc;
    logic [ILEN-1:0] r_out_inst;
    logic [XLEN-1:0] r_out_pc4;
    logic [XLEN-1:0] r_skid_pc;
    logic [ILEN-1:0] r_skid_inst;
    logic [XLEN-1:0] r_skid_pc4;

    logic            w_accept;
    logic            w_pop;
    logic            w_ld_out_in;
    logic            w_ld_out_skid;
    logic            w_ld_skid;
    logic            w_bubble;

    // All handshake outputs are decoded from the registered state only, so
    // there is no path from id_ready or flush to if_ready.
    assign bus.if_ready  = (r_state != S_FULL);
    assign bus.id_valid  = (r_state != S_EMPTY);
    assign bus.occupancy = r_state;
    assign bus.id_pc     = r_out_pc;
    assign bus.id_inst   = r_out_inst;
    assign bus.id_pc4    = r_out_pc4;

    assign w_accept = bus.if_valid & bus.if_ready;
    assign w_pop    = bus.id_valid & bus.id_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath load controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ld_out_in   = 1'b0;
        w_ld_out_skid = 1'b0;
        w_ld_skid     = 1'b0;
        w_bubble      = 1'b0;

        if (bus.flush) begin
            // Flush wins over everything, including a same-cycle accept.
            w_state_nxt = S_EMPTY;
            w_bubble    = 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_ld_out_in = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        w_ld_out_in = 1'b1;
                    end else if (w_accept) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = S_FULL;
                    end else if (w_pop) begin
                        w_bubble    = 1'b1;
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // if_ready is low here, so no accept can coincide.
                    if (w_pop) begin
                        w_ld_out_skid = 1'b1;
                        w_state_nxt   = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_bubble    = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // OUT and SKID registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_pc    <= '0;
            r_out_inst  <= NOP;
            r_out_pc4   <= '0;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_skid_pc4  <= '0;
        end else begin
            if (w_ld_out_in) begin
                r_out_pc   <= bus.if_pc;
                r_out_inst <= bus.if_inst;
                r_out_pc4  <= bus.if_pc4;
            end else if (w_ld_out_skid) begin
                r_out_pc   <= r_skid_pc;
                r_out_inst <= r_skid_inst;
                r_out_pc4  <= r_skid_pc4;
            end else if (w_bubble) begin
                // pc/pc4 keep stale values; only the instruction becomes a NOP.
                r_out_inst <= NOP;
            end

            if (w_ld_skid) begin
                r_skid_pc   <= bus.if_pc;
                r_skid_inst <= bus.if_inst;
                r_skid_pc4  <= bus.if_pc4;
            end
        end
    end

endmodule
`default_nettype wire
